shift_normalizer: RTL and testbench

//  Iterative normalizer: the inverse of the barrel shifter. Given an operand, it finds the shift

---
 rtl/shift_normalizer_pkg.sv | 18 +
 rtl/shift_normalizer_if.sv | 27 ++
 rtl/shift_normalizer_norm_stage.sv | 46 ++++
 rtl/shift_normalizer.sv | 132 +++++++++++++
 tb/tb_shift_normalizer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_normalizer_pkg.sv
// Shared types and constants for the iterative normalizer.
// State encodings are fixed so that debug dumps line up with the barrel shifter's.
// The mode constants match the barrel shifter's logical/arithmetic selector.
package shift_normalizer_pkg;

  localparam int SN_DATA_W  = 32;
  localparam int SN_SHAMT_W = 5;

  typedef enum logic [1:0] {
    SN_IDLE = 2'd0,
    SN_BUSY = 2'd1,
    SN_DONE = 2'd2
  } sn_state_e;

  localparam logic SHIFT_LOGIC = 1'b0;
  localparam logic SHIFT_ARITH = 1'b1;

endpackage

// File: rtl/shift_normalizer_if.sv
// Operand/result handshake bundle for shift_normalizer.
// master = operand source and result consumer, slave = the normalizer.
// Plain valid/ready on both directions; no credits.
interface shift_normalizer_if #(
  parameter int data_width      = 32,
  parameter int shift_amt_width = 5
);
  logic                       in_valid;
  logic                       in_ready;
  logic [data_width-1:0]      data_in;
  logic                       arith;
  logic                       out_valid;
  logic                       out_ready;
  logic [data_width-1:0]      data_out;
  logic [shift_amt_width-1:0] shift_amt;
  logic                       trivial;

  modport master (
    output in_valid, data_in, arith, out_ready,
    input  in_ready, out_valid, data_out, shift_amt, trivial
  );

  modport slave (
    input  in_valid, data_in, arith, out_ready,
    output in_ready, out_valid, data_out, shift_amt, trivial
  );
endinterface

// File: rtl/shift_normalizer_norm_stage.sv
// One binary-search step of the normalizer: tests the top 2**k (logical) or 2**k+1 (arith) bits.
// Latency: purely combinational.
// Backpressure: none; the caller sequences k.
module norm_stage
  import shift_normalizer_pkg::*;
#(
  parameter int data_width      = SN_DATA_W,
  parameter int shift_amt_width = SN_SHAMT_W
) (
  input  logic [data_width-1:0]      word_i,
  input  logic [shift_amt_width-1:0] k_i,
  input  logic                       arith_i,
  output logic [data_width-1:0]      word_o,
  output logic                       hit_o
);

  localparam logic [data_width-1:0] ALL_ONES = '1;

  logic [shift_amt_width:0] n_w;
  logic [shift_amt_width:0] n1_w;
  logic [data_width-1:0]    mask_n;
  logic [data_width-1:0]    mask_n1;
  logic [data_width-1:0]    top_n1;

  // n = 2**k; masks select the top n and top n+1 bits of the word
  assign n_w     = (shift_amt_width + 1)'(1) << k_i;
  assign n1_w    = n_w + (shift_amt_width + 1)'(1);
  assign mask_n  = ~(ALL_ONES >> n_w);
  assign mask_n1 = ~(ALL_ONES >> n1_w);
  assign top_n1  = word_i & mask_n1;

  // Hit when the tested field is redundant; a hit shifts it out with zero fill
  always_comb begin
    hit_o  = 1'b0;
    word_o = word_i;
    if (arith_i == SHIFT_ARITH) begin
      hit_o = (top_n1 == '0) || (top_n1 == mask_n1);
    end else begin
      hit_o = ((word_i & mask_n) == '0);
    end
    if (hit_o) begin
      word_o = word_i << n_w;
    end
  end

endmodule

// File: rtl/shift_normalizer.sv
// Iterative normalizer: leading-zero / redundant-sign count plus the normalized word.
// Latency: accept edge N, out_valid high after edge N+shift_amt_width+1.
// Backpressure: single operand in flight; in_ready only in IDLE, result held until out_ready.
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int data_width      = SN_DATA_W,
  parameter int shift_amt_width = SN_SHAMT_W
) (
  input logic               clk,
  input logic               rst_n,
  shift_normalizer_if.slave bus
);

  if (data_width != (1 << shift_amt_width)) begin : g_width_check
    $error("shift_normalizer: data_width must equal 2**shift_amt_width");
  end

  localparam logic [shift_amt_width-1:0] K_TOP = shift_amt_width'(shift_amt_width - 1);
  localparam logic [shift_amt_width-1:0] K_ONE = shift_amt_width'(1);

  sn_state_e                  state_q, state_d;
  logic [data_width-1:0]      work_q, work_d;
  logic [shift_amt_width-1:0] cnt_q, cnt_d;
  logic [shift_amt_width-1:0] k_q, k_d;
  logic                       mode_q, mode_d;
  logic                       triv_q, triv_d;
  // Result registers keep the outputs quiet while the working word iterates
  logic [data_width-1:0]      res_dat_q, res_dat_d;
  logic [shift_amt_width-1:0] res_amt_q, res_amt_d;
  logic                       res_triv_q, res_triv_d;
  logic                       out_vld_q, out_vld_d;

  logic [data_width-1:0]      stage_word;
  logic                       stage_hit;

  norm_stage #(
    .data_width      (data_width),
    .shift_amt_width (shift_amt_width)
  ) u_stage (
    .word_i  (work_q),
    .k_i     (k_q),
    .arith_i (mode_q),
    .word_o  (stage_word),
    .hit_o   (stage_hit)
  );

  // Next state: accept in IDLE, one search step per BUSY cycle, publish then hand off in DONE
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    mode_d     = mode_q;
    triv_d     = triv_q;
    res_dat_d  = res_dat_q;
    res_amt_d  = res_amt_q;
    res_triv_d = res_triv_q;
    out_vld_d  = out_vld_q;
    case (state_q)
      SN_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.data_in;
          mode_d  = bus.arith;
          cnt_d   = '0;
          triv_d  = (bus.data_in == '0) || (bus.arith && (&bus.data_in));
          k_d     = K_TOP;
          state_d = SN_BUSY;
        end
      end
      SN_BUSY: begin
        work_d     = stage_word;
        cnt_d[k_q] = stage_hit;
        if (k_q == '0) begin
          state_d = SN_DONE;
        end else begin
          k_d = k_q - K_ONE;
        end
      end
      SN_DONE: begin
        // First DONE cycle copies the finished search into the output registers
        if (!out_vld_q) begin
          res_dat_d  = work_q;
          res_amt_d  = cnt_q;
          res_triv_d = triv_q;
          out_vld_d  = 1'b1;
        end else if (bus.out_ready) begin
          out_vld_d = 1'b0;
          state_d   = SN_IDLE;
        end
      end
      default: begin
        state_d   = SN_IDLE;
        out_vld_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any operand in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SN_IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      mode_q     <= SHIFT_LOGIC;
      triv_q     <= 1'b0;
      res_dat_q  <= '0;
      res_amt_q  <= '0;
      res_triv_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      mode_q     <= mode_d;
      triv_q     <= triv_d;
      res_dat_q  <= res_dat_d;
      res_amt_q  <= res_amt_d;
      res_triv_q <= res_triv_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign bus.in_ready  = (state_q == SN_IDLE);
  assign bus.out_valid = out_vld_q;
  assign bus.data_out  = res_dat_q;
  assign bus.shift_amt = res_amt_q;
  assign bus.trivial   = res_triv_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed edge operands, back-pressure,
// mid-operation reset and a random sweep, all scored against a leading-run count model.
module tb_shift_normalizer;

  typedef struct {
    logic [31:0] din;
    logic        a;
    logic [31:0] dout;
    logic [4:0]  amt;
    logic        triv;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t q[$];
  exp_t cmp_e;
  logic [31:0] back_w;

  shift_normalizer_if #(.data_width(32), .shift_amt_width(5)) sif ();

  shift_normalizer #(.data_width(32), .shift_amt_width(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count the leading run of bits, convert to a shift, cap at 31
  function automatic exp_t model(input logic [31:0] d, input logic a);
    exp_t e;
    int   run;
    bit   stop;
    run  = 0;
    stop = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!stop) begin
        if (a ? (d[i] == d[31]) : (d[i] == 1'b0)) run++;
        else stop = 1'b1;
      end
    end
    if (a) run = run - 1;
    if (run > 31) run = 31;
    e.din  = d;
    e.a    = a;
    e.amt  = 5'(run);
    e.dout = d << run;
    e.triv = (d == 32'h0) || (a && (d == 32'hFFFF_FFFF));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle a result is offered it must match the oldest accepted operand
  always @(negedge clk) begin
    if (rst_n && sif.out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: result 0x%0h offered with no operand outstanding", sif.data_out);
      end else begin
        cmp_e = q[0];
        check("sb_data_out", sif.data_out, cmp_e.dout);
        check("sb_shift_amt", 32'(sif.shift_amt), 32'(cmp_e.amt));
        check("sb_trivial", 32'(sif.trivial), 32'(cmp_e.triv));
        check("sb_in_ready_low", 32'(sif.in_ready), 32'd0);
        if (!cmp_e.triv) begin
          back_w = cmp_e.a ? 32'($signed(sif.data_out) >>> sif.shift_amt)
                           : (sif.data_out >> sif.shift_amt);
          check("sb_barrel_restore", back_w, cmp_e.din);
        end
        if (sif.out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic a);
    int w;
    sif.in_valid = 1'b1;
    sif.data_in  = d;
    sif.arith    = a;
    w = 0;
    while (!sif.in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!sif.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles", w);
    end
    @(posedge clk);
    q.push_back(model(d, a));
    #1;
    sif.in_valid = 1'b0;
    sif.data_in  = $urandom;
    sif.arith    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!sif.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] d, input logic a,
                        input logic [31:0] e_dout, input logic [4:0] e_amt, input logic e_triv);
    exp_t m;
    int   lat;
    m = model(d, a);
    check("model_amt", 32'(m.amt), 32'(e_amt));
    check("model_dout", m.dout, e_dout);
    check("model_triv", 32'(m.triv), 32'(e_triv));
    send(d, a);
    wait_valid(lat);
    check("latency", 32'(lat), 32'd6);
    check("dir_shift_amt", 32'(sif.shift_amt), 32'(e_amt));
    check("dir_data_out", sif.data_out, e_dout);
    check("dir_trivial", 32'(sif.trivial), 32'(e_triv));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dir_d    [8] = '{32'h0000_0001, 32'h00F0_0000, 32'hFFFF_0000, 32'h0000_0001,
                                32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
  logic        dir_a    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] dir_dout [8] = '{32'h8000_0000, 32'hF000_0000, 32'h8000_0000, 32'h4000_0000,
                                32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [4:0]  dir_amt  [8] = '{5'd31, 5'd8, 5'd15, 5'd30, 5'd0, 5'd31, 5'd31, 5'd0};
  logic        dir_triv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] r;
    logic [31:0] d;
    logic        a;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    sif.in_valid  = 1'b0;
    sif.data_in   = '0;
    sif.arith     = 1'b0;
    sif.out_ready = 1'b1;

    #2;
    check("rst_in_ready", 32'(sif.in_ready), 32'd1);
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_data_out", sif.data_out, 32'd0);
    check("rst_shift_amt", 32'(sif.shift_amt), 32'd0);
    check("rst_trivial", 32'(sif.trivial), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_op(dir_d[i], dir_a[i], dir_dout[i], dir_amt[i], dir_triv[i]);
    end

    // Back-pressure: result held for 10 cycles while a new operand is offered
    sif.out_ready = 1'b0;
    send(32'h00F0_0000, 1'b0);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd6);
    for (int i = 0; i < 10; i++) begin
      sif.in_valid = 1'b1;
      sif.data_in  = 32'h1234_5678;
      sif.arith    = 1'b0;
      check("bp_out_valid", 32'(sif.out_valid), 32'd1);
      check("bp_in_ready", 32'(sif.in_ready), 32'd0);
      check("bp_data_out", sif.data_out, 32'hF000_0000);
      check("bp_shift_amt", 32'(sif.shift_amt), 32'd8);
      @(posedge clk);
      #1;
    end
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(sif.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(sif.in_ready), 32'd1);

    // Reset while the search sits at stage 2
    send(32'h0000_0F00, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(sif.in_ready), 32'd1);
    check("mid_rst_data_out", sif.data_out, 32'd0);
    check("mid_rst_shift_amt", 32'(sif.shift_amt), 32'd0);
    check("mid_rst_trivial", 32'(sif.trivial), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'h0000_0F00, 1'b0, 32'hF000_0000, 5'd20, 1'b0);

    // Random operands with a spread of leading-run lengths in both modes
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      d = r >> $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       d = ~d;
        1:       d = r;
        2:       d = 32'h1 << $urandom_range(0, 31);
        default: d = d;
      endcase
      a = 1'($urandom_range(0, 1));
      send(d, a);
      wait_valid(lat);
      check("rnd_latency", 32'(lat), 32'd6);
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("pending_results", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
